// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one completing execution unit per cycle and
// drives the registered CDB broadcast. Define CDB_RR_EN for round-robin; default is fixed priority.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*TAG_W-1:0]          req_tag,
  input  logic [N_REQ*DATA_W-1:0]         req_data,
  input  logic                            tf_full,
  output logic [N_REQ-1:0]                grant,
  output logic                            cdb_valid,
  output logic [TAG_W-1:0]                cdb_tag,
  output logic [DATA_W-1:0]               cdb_data,
  output logic [$clog2(N_REQ)-1:0]        cdb_src
);

  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0][TAG_W-1:0]  tag_arr;
  logic [N_REQ-1:0][DATA_W-1:0] data_arr;
  logic [SRC_W-1:0]             win;
  logic                         found;
  logic                         xfer;
  int                           idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

`ifdef CDB_RR_EN
  logic [SRC_W-1:0] ptr;
`endif

  // Search order: from the pointer upward with wrap (round-robin) or from unit 0 (fixed).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CDB_RR_EN
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
`else
      idx = k;
`endif
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!rst && !tf_full && found) grant[win] = 1'b1;
  end

  assign xfer = |grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        cdb_tag  <= tag_arr[win];
        cdb_data <= data_arr[win];
        cdb_src  <= win;
      end
    end
  end

`ifdef CDB_RR_EN
  // Pointer moves past the winner only when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (xfer) ptr <= (win == SRC_W'(N_REQ-1)) ? '0 : win + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of grant vectors plus hand-written
// sequences for reset, tf_full stall, reset mid-transfer and a 64-tag stream.
module tb_cdb_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        rv;
  logic [3:0][5:0]   tags;
  logic [3:0][31:0]  datas;
  logic              tf;
  logic [3:0]        grant;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic [1:0]        cdb_src;

  int checks = 0;
  int fails  = 0;

  cdb_arbiter #(.N_REQ(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_tag(tags), .req_data(datas),
    .tf_full(tf), .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    logic       tf;
    logic [3:0] g_fp;
    logic [3:0] g_rr;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rv = '0; tf = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    oh2idx = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) oh2idx = 2'(i);
  endfunction

  logic [3:0] exp_g;
  int         pulses;

  initial begin
    //              rv       tf    fixed    round-robin
    vec[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
    vec[1]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100};
    vec[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
    vec[3]  = '{4'b1111, 1'b0, 4'b0001, 4'b1000};
    vec[4]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
    vec[5]  = '{4'b1111, 1'b0, 4'b0001, 4'b0010};
    vec[6]  = '{4'b1111, 1'b1, 4'b0000, 4'b0000};
    vec[7]  = '{4'b1010, 1'b0, 4'b0010, 4'b1000};
    vec[8]  = '{4'b1010, 1'b0, 4'b0010, 4'b0010};
    vec[9]  = '{4'b1000, 1'b0, 4'b1000, 4'b1000};
    vec[10] = '{4'b0110, 1'b0, 4'b0010, 4'b0010};
    vec[11] = '{4'b0011, 1'b0, 4'b0001, 4'b0001};
    vec[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};

    rst = 1'b1; rv = '0; tf = 1'b0; tags = '0; datas = '0;
    repeat (2) tick();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag",   64'(cdb_tag),   64'd0);
    chk("rst_data",  64'(cdb_data),  64'd0);
    chk("rst_src",   64'(cdb_src),   64'd0);
    rv = 4'b1111;
    #1 chk("rst_grant_forced0", 64'(grant), 64'd0);
    tick();
    chk("rst_no_bcast", 64'(cdb_valid), 64'd0);
    rv = '0; rst = 1'b0;

    // Single request on unit 2
    rv = 4'b0100; tags[2] = 6'd17; datas[2] = 32'hDEAD_BEEF;
    #1 chk("t1_grant", 64'(grant), 64'b0100);
    tick();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag",   64'(cdb_tag),   64'd17);
    chk("t1_data",  64'(cdb_data),  64'hDEAD_BEEF);
    chk("t1_src",   64'(cdb_src),   64'd2);
    rv = '0;
    tick();
    chk("t1_valid_drop", 64'(cdb_valid), 64'd0);

    do_reset();
`ifdef CDB_RR_EN
    rv = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      #1 chk("t2_rr_grant", 64'(grant), 64'(4'b0001 << j));
      tick();
      chk("t2_rr_src", 64'(cdb_src), 64'(j));
      chk("t2_rr_valid", 64'(cdb_valid), 64'd1);
    end
`else
    rv = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t3_fp_grant", 64'(grant), 64'b0010);
      tick();
      chk("t3_fp_src", 64'(cdb_src), 64'd1);
    end
    rv = 4'b1000;
    #1 chk("t3_fp_grant_u3", 64'(grant), 64'b1000);
    tick();
    chk("t3_fp_src_u3", 64'(cdb_src), 64'd3);
`endif
    rv = '0;
    do_reset();

    // tf_full stall with unit 0 pending
    rv = 4'b0001; tags[0] = 6'd9; datas[0] = 32'h0000_0909; tf = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1 chk("t4_stall_grant", 64'(grant), 64'd0);
      tick();
      chk("t4_stall_valid", 64'(cdb_valid), 64'd0);
    end
    tf = 1'b0;
    #1 chk("t4_resume_grant", 64'(grant), 64'b0001);
    tick();
    chk("t4_resume_valid", 64'(cdb_valid), 64'd1);
    chk("t4_resume_tag",   64'(cdb_tag),   64'd9);
    rv = '0;
    tick();

    // Reset immediately after a transfer
    do_reset();
    rv = 4'b0100; tags[2] = 6'd5;
    #1 chk("t5_grant", 64'(grant), 64'b0100);
    tick();
    chk("t5_valid_T1", 64'(cdb_valid), 64'd1);
    chk("t5_tag_T1",   64'(cdb_tag),   64'd5);
    rst = 1'b1; rv = 4'b1111;
    #1 chk("t5_grant_in_rst", 64'(grant), 64'd0);
    tick();
    chk("t5_valid_T2", 64'(cdb_valid), 64'd0);
    rst = 1'b0;
    #1 chk("t5_ptr0_grant", 64'(grant), 64'b0001);
    tick();
    chk("t5_ptr0_src", 64'(cdb_src), 64'd0);
    rv = '0;
    tick();

    // Table-driven vectors from a fresh reset
    do_reset();
    for (int k = 0; k < 13; k++) begin
      rv = vec[k].rv; tf = vec[k].tf;
      for (int i = 0; i < 4; i++) begin
        tags[i]  = 6'((k*4 + i) % 64);
        datas[i] = 32'hC0DE_0000 + 32'(k*16 + i);
      end
`ifdef CDB_RR_EN
      exp_g = vec[k].g_rr;
`else
      exp_g = vec[k].g_fp;
`endif
      #1 chk($sformatf("vec%0d_grant", k), 64'(grant), 64'(exp_g));
      tick();
      chk($sformatf("vec%0d_valid", k), 64'(cdb_valid), 64'(|exp_g));
      if (exp_g != 4'b0000) begin
        chk($sformatf("vec%0d_src", k),  64'(cdb_src),  64'(oh2idx(exp_g)));
        chk($sformatf("vec%0d_tag", k),  64'(cdb_tag),  64'((k*4 + oh2idx(exp_g)) % 64));
        chk($sformatf("vec%0d_data", k), 64'(cdb_data), 64'(32'hC0DE_0000 + 32'(k*16 + oh2idx(exp_g))));
      end
    end
    rv = '0; tf = 1'b0;

    // 64 back-to-back single-unit transfers, tags 0..63
    do_reset();
    pulses = 0;
    for (int k = 0; k < 64; k++) begin
      rv = 4'b0001 << (k % 4);
      tags[k % 4] = 6'(k);
      tick();
      if (cdb_valid) pulses++;
      chk("t6_valid", 64'(cdb_valid), 64'd1);
      chk("t6_tag",   64'(cdb_tag),   64'(k));
    end
    rv = '0;
    tick();
    chk("t6_tail_valid", 64'(cdb_valid), 64'd0);
    chk("t6_pulses", 64'(pulses), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
